// File: rtl/phys_mem_responder_pkg.sv
// Shared LC-3b memory-interface types.
//   lc3b_word       : 16-bit byte address / data word
//   lc3b_line       : 128-bit cache line (16 bytes)
//   lc3b_pmem_state : responder FSM state (idle, counting latency, completion pulse)
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    PmemIdle = 2'd0,
    PmemBusy = 2'd1,
    PmemResp = 2'd2
  } lc3b_pmem_state;

endpackage

// File: rtl/phys_mem_responder_array.sv
// Line storage for the physical-memory responder: 2**INDEX_W lines of 128 bits.
//   clk, reset : clock; reset clears only the read-data register, never the lines
//   we, idx, din : synchronous line write
//   re, dout     : registered line read; dout holds its value until the next re
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [INDEX_W-1:0] idx,
  input  logic [127:0]       din,
  output logic [127:0]       dout
);

  lc3b_line mem [2**INDEX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (re) begin
      dout <= mem[idx];
    end
  end

endmodule

// File: rtl/phys_mem_responder.sv
// Physical-memory responder beneath the data cache. Captures one line-granular read or
// write request, waits LATENCY cycles, then pulses pmem_resp for one cycle.
//   clk, reset   : clock; asynchronous active-high reset (aborts any transfer in flight)
//   pmem_address : byte address, bits [3:0] ignored, bits above the index alias
//   pmem_read    : read-line request, held until pmem_resp
//   pmem_write   : write-line request, held until pmem_resp (wins over read)
//   pmem_wdata   : write line
//   pmem_rdata   : read line, updated only when a read completes
//   pmem_resp    : one-cycle completion pulse
//   busy         : high from capture edge through the pmem_resp cycle
//   proto_err    : sticky flag, read and write seen together at capture
module phys_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned INDEX_W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         busy,
  output logic         proto_err
);

  localparam logic [7:0] CntLoad     = 8'(LATENCY - 1);
  localparam bit         SingleCycle = (LATENCY == 1);

  lc3b_pmem_state     state_q;
  logic [7:0]         cnt_q;
  logic [INDEX_W-1:0] idx_q;
  logic               wr_q;
  logic [127:0]       wdata_q;

  logic               req;
  logic               in_idle;
  logic               enter_resp;
  logic               op_wr;
  logic [INDEX_W-1:0] op_idx;
  logic [127:0]       op_wdata;
  logic               arr_we;
  logic               arr_re;
  logic               unused_addr;

  assign unused_addr = ^pmem_address[3:0];

  // With LATENCY==1 the capture edge is also the commit edge, so the array must see the
  // live request rather than the (not yet loaded) capture registers.
  always_comb begin
    req        = pmem_read | pmem_write;
    in_idle    = (state_q == PmemIdle);
    enter_resp = ((state_q == PmemBusy) && (cnt_q == 8'd1)) || (in_idle && req && SingleCycle);
    op_wr      = in_idle ? pmem_write : wr_q;
    op_idx     = in_idle ? pmem_address[INDEX_W+3:4] : idx_q;
    op_wdata   = in_idle ? pmem_wdata : wdata_q;
    arr_we     = enter_resp & op_wr;
    arr_re     = enter_resp & ~op_wr;
  end

  // Outputs are kept in lockstep with the state so they never depend on inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PmemIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      proto_err <= 1'b0;
      pmem_resp <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        PmemIdle: begin
          if (req) begin
            idx_q   <= pmem_address[INDEX_W+3:4];
            wr_q    <= pmem_write;
            wdata_q <= pmem_wdata;
            cnt_q   <= CntLoad;
            busy    <= 1'b1;
            if (pmem_read && pmem_write) begin
              proto_err <= 1'b1;
            end
            if (SingleCycle) begin
              state_q   <= PmemResp;
              pmem_resp <= 1'b1;
            end else begin
              state_q <= PmemBusy;
            end
          end
        end
        PmemBusy: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q   <= PmemResp;
            pmem_resp <= 1'b1;
          end
        end
        PmemResp: begin
          // Requests still held here belong to the op just completed; never re-capture.
          state_q   <= PmemIdle;
          pmem_resp <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_q   <= PmemIdle;
          pmem_resp <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  pmem_line_array #(
    .INDEX_W(INDEX_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (op_idx),
    .din  (op_wdata),
    .dout (pmem_rdata)
  );

endmodule
